// File: rtl/sevenseg_pkg.sv
// Shared types and segment patterns for the BCD seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g} with a in bit 6; a 1 lights the segment.
package sevenseg_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SEG_W    = 7;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [SEG_W-1:0]    seg_t;

  localparam nibble_t BCD_MAX = 4'd9;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic logic is_invalid(input nibble_t n);
    return n > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_sevenseg_scan_driver_if.sv
// Load/display bundle of the scan driver: BCD word in, segment/digit pins out.
// The datapath side is the master; the scan driver itself is the slave.
interface bcd_sevenseg_scan_driver_if #(
  parameter int DIGITS = 4
);
  import sevenseg_pkg::*;

  logic                         load;
  logic [NIBBLE_W*DIGITS-1:0]   bcd_in;
  seg_t                         seg;
  logic [DIGITS-1:0]            dig_en;
  logic                         frame_start;
  logic                         invalid;

  modport master (
    output load, bcd_in,
    input  seg, dig_en, frame_start, invalid
  );

  modport slave (
    input  load, bcd_in,
    output seg, dig_en, frame_start, invalid
  );

endinterface

// File: rtl/bcd_sevenseg_decode.sv
// Combinational BCD nibble to seven-segment decoder; codes 10..15 are blank.
module bcd_sevenseg_decode
  import sevenseg_pkg::*;
(
  input  nibble_t digit,
  output seg_t    seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan_driver.sv
// Time-multiplexed common-cathode seven-segment scan driver with tear-free display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the leading non-zero.
module bcd_sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  bcd_sevenseg_scan_driver_if.slave     bus
);

  localparam int PC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DI_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BUS_W = NIBBLE_W * DIGITS;

  logic [PC_W-1:0]  pc;
  logic [DI_W-1:0]  di;
  logic [BUS_W-1:0] shd;
  logic [BUS_W-1:0] disp;

  logic    pc_wrap;
  logic    frame_wrap;
  nibble_t cur_nibble;
  seg_t    cur_seg;
  logic    blank;
  logic    any_invalid;

  assign pc_wrap    = (pc == PC_W'(PRESCALE - 1));
  assign frame_wrap = pc_wrap && (di == DI_W'(DIGITS - 1));
  assign cur_nibble = disp[NIBBLE_W*di +: NIBBLE_W];

  bcd_sevenseg_decode u_decode (
    .digit (cur_nibble),
    .seg   (cur_seg)
  );

  // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      any_invalid |= is_invalid(disp[NIBBLE_W*i +: NIBBLE_W]);
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank the current digit only if it and every digit above it hold zero.
  always_comb begin
    blank = (di != '0);
    for (int i = 0; i < DIGITS; i++)
      if (i >= int'(di) && disp[NIBBLE_W*i +: NIBBLE_W] != '0)
        blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= '0;
      di              <= '0;
      shd             <= '0;
      disp            <= '0;
      bus.seg         <= SEG_BLANK;
      bus.dig_en      <= '0;
      bus.frame_start <= 1'b0;
      bus.invalid     <= 1'b0;
    end else begin
      pc <= pc_wrap ? '0 : pc + 1'b1;
      if (pc_wrap)
        di <= (di == DI_W'(DIGITS - 1)) ? '0 : di + 1'b1;
      if (bus.load)
        shd <= bus.bcd_in;
      // A load on the wrap cycle bypasses the shadow so it shows in the new frame.
      if (frame_wrap)
        disp <= bus.load ? bus.bcd_in : shd;
      bus.seg         <= blank ? SEG_BLANK : cur_seg;
      bus.dig_en      <= DIGITS'(1) << di;
      bus.frame_start <= (pc == '0) && (di == '0);
      bus.invalid     <= any_invalid;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scan_driver.sv
// Directed bench for the scan driver: a 4-digit/PRESCALE=3 unit plus a 1-digit/PRESCALE=1 unit.
module tb_bcd_sevenseg_scan_driver;
  import sevenseg_pkg::*;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 3;
  localparam int FRAME    = DIGITS * PRESCALE;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam seg_t SEG_Z = LZB ? SEG_BLANK : SEG_0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_sevenseg_scan_driver_if #(.DIGITS(DIGITS)) bus  ();
  bcd_sevenseg_scan_driver_if #(.DIGITS(1))      bus1 ();

  bcd_sevenseg_scan_driver #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bcd_sevenseg_scan_driver #(.DIGITS(1), .PRESCALE(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks one full output frame starting at its frame_start edge, optionally loading twice.
  task automatic run_frame(input string name,
                           input seg_t e0, input seg_t e1, input seg_t e2, input seg_t e3,
                           input logic inv,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    seg_t       exp_seg [DIGITS];
    logic [3:0] exp_en;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    for (int k = 0; k < FRAME; k++) begin
      if (k == la) begin bus.load = 1'b1; bus.bcd_in = va; end
      if (k == lb) begin bus.load = 1'b1; bus.bcd_in = vb; end
      step();
      bus.load = 1'b0;
      exp_en = 4'b0001 << (k / PRESCALE);
      check($sformatf("%s dig_en k%0d", name, k), bus.dig_en, exp_en);
      check($sformatf("%s frame_start k%0d", name, k), bus.frame_start, (k == 0));
      check($sformatf("%s seg k%0d", name, k), bus.seg, exp_seg[k / PRESCALE]);
      check($sformatf("%s invalid k%0d", name, k), bus.invalid, inv);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.load    = 1'b0;
    bus.bcd_in  = '0;
    bus1.load   = 1'b0;
    bus1.bcd_in = '0;
    @(negedge clk);
    step();
    check("reset seg", bus.seg, SEG_BLANK);
    check("reset dig_en", bus.dig_en, 4'b0000);
    check("reset frame_start", bus.frame_start, 1'b0);
    check("reset invalid", bus.invalid, 1'b0);
    check("reset d1 dig_en", bus1.dig_en, 1'b0);

    rst = 1'b0;
    run_frame("idle", SEG_0, SEG_Z, SEG_Z, SEG_Z, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame("pre1987", SEG_0, SEG_Z, SEG_Z, SEG_Z, 1'b0, 5, 16'h1987, -1, 16'h0);
    run_frame("1987", SEG_7, SEG_8, SEG_9, SEG_1, 1'b0, 1, 16'h00A5, -1, 16'h0);
    run_frame("00A5", SEG_5, SEG_BLANK, SEG_Z, SEG_Z, 1'b1, FRAME - 1, 16'h2222, -1, 16'h0);
    run_frame("bypass2222", SEG_2, SEG_2, SEG_2, SEG_2, 1'b0, 0, 16'h0040, -1, 16'h0);
    run_frame("0040", SEG_0, SEG_4, SEG_Z, SEG_Z, 1'b0, 3, 16'h0000, -1, 16'h0);
    run_frame("0000", SEG_0, SEG_Z, SEG_Z, SEG_Z, 1'b0, 2, 16'h1111, 7, 16'h3456);
    run_frame("lastwins3456", SEG_6, SEG_5, SEG_4, SEG_3, 1'b0, -1, 16'h0, -1, 16'h0);

    // Park a value in the shadow, then reset while digit 2 is the internal index.
    bus.load   = 1'b1;
    bus.bcd_in = 16'h7777;
    step();
    bus.load = 1'b0;
    for (int k = 1; k < 2 * PRESCALE; k++) step();
    check("pre-rst dig_en", bus.dig_en, 4'b0010);
    rst = 1'b1;
    step();
    check("mid rst seg", bus.seg, SEG_BLANK);
    check("mid rst dig_en", bus.dig_en, 4'b0000);
    check("mid rst frame_start", bus.frame_start, 1'b0);
    check("mid rst invalid", bus.invalid, 1'b0);
    rst = 1'b0;
    run_frame("post-rst", SEG_0, SEG_Z, SEG_Z, SEG_Z, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame("shd-cleared", SEG_0, SEG_Z, SEG_Z, SEG_Z, 1'b0, -1, 16'h0, -1, 16'h0);

    // Single digit, PRESCALE=1: every cycle is a frame wrap, so loads bypass at once.
    bus1.load   = 1'b1;
    bus1.bcd_in = 4'h6;
    step();
    bus1.load = 1'b0;
    check("d1 dig_en", bus1.dig_en, 1'b1);
    check("d1 frame_start a", bus1.frame_start, 1'b1);
    check("d1 seg old", bus1.seg, SEG_0);
    step();
    check("d1 seg 6", bus1.seg, SEG_6);
    check("d1 frame_start b", bus1.frame_start, 1'b1);
    check("d1 invalid 6", bus1.invalid, 1'b0);
    bus1.load   = 1'b1;
    bus1.bcd_in = 4'hC;
    step();
    bus1.load = 1'b0;
    check("d1 seg hold", bus1.seg, SEG_6);
    step();
    check("d1 seg C", bus1.seg, SEG_BLANK);
    check("d1 invalid C", bus1.invalid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_scan_driver.md
# bcd_sevenseg_scan_driver

Time-multiplexed driver for a parametrised bank of common-cathode seven-segment digits. Accepts a packed multi-digit BCD word, holds it in a tear-free display register, and scans one digit at a time at a programmable rate, producing active-high segments {a..g} and a one-hot digit enable. Sits between the datapath that produces BCD values and the board display pins.

## Interface
- DIGITS, 4: number of digits scanned, legal range 1..8.
- PRESCALE, 1000: clock cycles each digit is held active, minimum 1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  when 1, capture bcd_in this cycle.
- bcd_in  in  4*DIGITS  packed BCD; digit 0 = bits [3:0] (least significant).
- seg  out  7  segments {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g; 1 = lit.
- dig_en  out  DIGITS  one-hot digit enable, bit i drives digit i.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.
- invalid  out  1  1 while any displayed nibble is >9.

## Operation
- Internal state: prescale counter pc (0..PRESCALE-1), digit index di (0..DIGITS-1), shadow register shd, display register disp.
- Reset: pc=0, di=0, shd=0, disp=0; seg=0, dig_en=0, frame_start=0, invalid=0.
- pc increments every cycle; at PRESCALE-1 it wraps to 0 and di advances; di wraps from DIGITS-1 to 0 (frame wrap).
- load=1: shd <= bcd_in. Multiple loads within a frame: last one wins.
- At frame wrap: disp <= shd. On the same cycle as load=1 the new bcd_in bypasses to disp directly.
- Decode per nibble: 0..9 map to 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011; 10..15 map to 0000000 (blank).
- Outputs registered: seg <= decode(disp nibble di), dig_en <= 1<<di, invalid <= OR over nibbles of (nibble>9).
- frame_start asserts on the cycle where dig_en first becomes ...0001 in each frame, including the first frame after reset.
- DIGITS=1: dig_en constant 1 after reset; frame_start pulses every PRESCALE cycles.
- rst mid-frame: everything returns to reset values on the next edge; shd content discarded.

## Timing
- Outputs lag internal state by one cycle.
- First edge with rst=0: dig_en=…0001, seg=decode(disp[3:0]) (1111110 after reset), frame_start=1.
- Each digit active exactly PRESCALE consecutive cycles; frame period DIGITS*PRESCALE cycles; no dead cycles between digits.
- load-to-display latency: at most one frame plus one cycle; a value never appears partially (no tearing within a frame).
- PRESCALE=1: di advances every cycle; every cycle is a pc wrap.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits above the most-significant non-zero digit of disp that hold 0 output seg=0000000; digit 0 is never blanked (value 0 shows a single "0"). Invalid nibbles count as non-zero for this rule.
- Not defined: all digits always decoded, zeros shown.
- dig_en, timing and invalid identical in both builds.

## Structure
- Package sevenseg_pkg: segment constants SEG_0..SEG_9 and SEG_BLANK (7-bit), BCD_MAX=9, nibble width constant.
- Sub-module bcd_sevenseg_decode: purely combinational 4-bit → 7-bit decoder using the package constants; instantiated once on the mux output of disp.
- Top holds counters, shd/disp registers, leading-zero mask logic and output registers.

## Test plan
- Reset then DIGITS=4, PRESCALE=3, no load → dig_en cycles 0001,0010,0100,1000 each 3 cycles, seg=1111110 throughout, frame_start every 12 cycles.
- load bcd_in=16'h1987 mid-frame → unchanged until next frame_start, then digits 0..3 show 1110000, 1111111, 1111011, 0110000.
- load 16'h00A5 → invalid=1 from frame start; digit 1 seg=0000000; digit 0 seg=1011011.
- LEADING_ZERO_BLANK_EN, load 16'h0040 → digits 3,2 blank, digit 1 0110011, digit 0 1111110; load 16'h0000 → only digit 0 shows 1111110.
- load asserted on frame-wrap cycle with 16'h2222 → displayed in the frame starting that edge (bypass).
- rst asserted with di=2 → next edge all outputs 0; first edge after release dig_en=0001, frame_start=1, disp=0.
